// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared constants for the decode stage and its register file
// Holds opcode classes, instruction field positions, register-file geometry and
// the writeback-bypass switch selected by macro DECODE_WB_BYPASS_EN.
package decode_stage_pkg;
    localparam int NREGS = 8;
    localparam int DW = 16;
    localparam int AW = $clog2(NREGS);
    localparam logic [1:0] CLS_R = 2'b11;
    localparam logic [1:0] CLS_M = 2'b10;
    localparam logic [1:0] CLS_I = 2'b01;
    localparam logic [1:0] CLS_J = 2'b00;
    localparam int LS_BIT = 2;
    localparam int OP_HI = 15;
    localparam int OP_LO = 11;
    localparam int RD_HI = 10;
    localparam int RD_LO = 8;
    localparam int RS_HI = 7;
    localparam int RS_LO = 5;
    localparam int RT_HI = 4;
    localparam int RT_LO = 2;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif
    function automatic logic [1:0] op_class(input logic [4:0] op);
        return op[4:3];
    endfunction
endpackage

// File: rtl/dec_regfile.sv
// dec_regfile: 8x16 register file, R0 reads zero, three combinational reads, one write
// Ports: clk, rst_n (async active-low); wb_en/wb_addr/wb_data write port;
// ra1/ra2/ra3 -> rd1/rd2/rd3 combinational reads. With DECODE_WB_BYPASS_EN a read
// of the register being written this cycle returns wb_data.
module dec_regfile
    import decode_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] ra3,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] rd3
);
    logic [DW-1:0] mem [NREGS];

    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] a);
        return (a == '0) ? '0 : (WB_BYPASS && wb_en && wb_addr == a) ? wb_data : mem[a];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            mem[wb_addr] <= wb_data;
        end
    end

    assign rd1 = read_port(ra1);
    assign rd2 = read_port(ra2);
    assign rd3 = read_port(ra3);
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes one instruction per cycle into a registered execute bundle
// Ports: clk, rst_n (async active-low); fetch instr_valid/instr/instr_ready;
// writeback wb_en/wb_addr/wb_data; execute control ex_stall/flush; registered
// outputs ex_valid/ex_opcode/ex_alu_in1/ex_alu_in2/ex_imm/ex_rd/ex_wb_en.
// Macro DECODE_WB_BYPASS_EN lets a reader issue in the same cycle as its writeback.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [DW-1:0] instr,
    output logic          instr_ready,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          ex_stall,
    input  logic          flush,
    output logic          ex_valid,
    output logic [4:0]    ex_opcode,
    output logic [DW-1:0] ex_alu_in1,
    output logic [DW-1:0] ex_alu_in2,
    output logic [7:0]    ex_imm,
    output logic [AW-1:0] ex_rd,
    output logic          ex_wb_en
);
    logic [4:0]       op;
    logic [1:0]       cls;
    logic [AW-1:0]    rd, rs, rt;
    logic             is_st, writes, hazard, issue;
    logic [NREGS-1:0] sb, sb_n, busy, src, wb_hot;
    logic [DW-1:0]    r_rs, r_rt, r_rd;

    assign op     = instr[OP_HI:OP_LO];
    assign cls    = op_class(op);
    assign rd     = instr[RD_HI:RD_LO];
    assign rs     = instr[RS_HI:RS_LO];
    assign rt     = instr[RT_HI:RT_LO];
    assign is_st  = cls == CLS_M && op[LS_BIT];
    assign writes = (cls == CLS_R || cls == CLS_I || (cls == CLS_M && !op[LS_BIT])) && rd != '0;
    assign wb_hot = (wb_en && wb_addr != '0) ? NREGS'(1) << wb_addr : '0;

    dec_regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra1     (rs),
        .ra2     (rt),
        .ra3     (rd),
        .rd1     (r_rs),
        .rd2     (r_rt),
        .rd3     (r_rd)
    );

    always_comb begin
        src = '0;
        if (cls == CLS_R || cls == CLS_M) src[rs] = 1'b1;
        if (cls == CLS_R) src[rt] = 1'b1;
        if (cls == CLS_I || is_st) src[rd] = 1'b1;
        src[0] = 1'b0;
    end

    // Without bypass the register being written back stays busy this cycle, so the
    // dependent instruction waits one more cycle and reads the updated file.
    assign busy        = sb & ~(WB_BYPASS ? wb_hot : '0);
    assign hazard      = |(src & busy);
    assign instr_ready = rst_n && !ex_stall && !hazard && !flush;
    assign issue       = instr_valid && instr_ready;

    // Clears first so a same-cycle set of the same register wins.
    always_comb begin
        sb_n = sb & ~wb_hot;
        if (flush && ex_valid && ex_wb_en) sb_n[ex_rd] = 1'b0;
        if (issue && writes) sb_n[rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb         <= '0;
            ex_valid   <= 1'b0;
            ex_opcode  <= '0;
            ex_alu_in1 <= '0;
            ex_alu_in2 <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_wb_en   <= 1'b0;
        end else begin
            sb <= sb_n;
            if (issue) begin
                ex_valid   <= 1'b1;
                ex_opcode  <= op;
                ex_alu_in1 <= (cls == CLS_I) ? r_rd : r_rs;
                ex_alu_in2 <= (cls == CLS_R) ? r_rt : is_st ? r_rd : '0;
                ex_imm     <= instr[IMM_HI:IMM_LO];
                ex_rd      <= rd;
                ex_wb_en   <= writes;
            end else if (!ex_stall || flush) begin
                ex_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with a spec-level reference model
module tb_decode_stage;
    logic        clk, rst_n, instr_valid, instr_ready, wb_en, ex_stall, flush;
    logic [15:0] instr, wb_data, ex_alu_in1, ex_alu_in2;
    logic [2:0]  wb_addr, ex_rd;
    logic        ex_valid, ex_wb_en;
    logic [4:0]  ex_opcode;
    logic [7:0]  ex_imm;
    int n_cmp = 0;
    int n_err = 0;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_alu_in1(ex_alu_in1), .ex_alu_in2(ex_alu_in2), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_wb_en(ex_wb_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic v; logic [4:0] op; logic [15:0] a1; logic [15:0] a2;
        logic [7:0] imm; logic [2:0] rd; logic we;
    } ex_t;

    logic [15:0] mreg [8];
    logic [7:0]  mbusy;
    ex_t         mex;

    function automatic logic [7:0] srcs(input logic [15:0] i);
        logic [7:0] m = '0;
        case (i[15:14])
            2'b11: begin m[i[7:5]] = 1'b1; m[i[4:2]] = 1'b1; end
            2'b10: begin m[i[7:5]] = 1'b1; if (i[13]) m[i[10:8]] = 1'b1; end
            2'b01: m[i[10:8]] = 1'b1;
            default: m = '0;
        endcase
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic [15:0] rv(input logic [2:0] a);
        if (a == 3'd0) return 16'h0;
        if (BYP && wb_en && wb_addr == a) return wb_data;
        return mreg[a];
    endfunction

    function automatic logic m_ready();
        logic [7:0] b = mbusy;
        if (BYP && wb_en) b[wb_addr] = 1'b0;
        return rst_n && !ex_stall && !flush && (srcs(instr) & b) == 8'h0;
    endfunction

    function automatic ex_t m_dec();
        ex_t e;
        logic [1:0] c = instr[15:14];
        e.v   = 1'b1;
        e.op  = instr[15:11];
        e.a1  = (c == 2'b01) ? rv(instr[10:8]) : rv(instr[7:5]);
        e.a2  = (c == 2'b11) ? rv(instr[4:2]) : (c == 2'b10 && instr[13]) ? rv(instr[10:8]) : 16'h0;
        e.imm = instr[7:0];
        e.rd  = instr[10:8];
        e.we  = (c == 2'b11 || c == 2'b01 || (c == 2'b10 && !instr[13])) && instr[10:8] != 3'd0;
        return e;
    endfunction

    function automatic logic [7:0] next_busy();
        logic [7:0] b = mbusy;
        if (wb_en) b[wb_addr] = 1'b0;
        if (flush && mex.v && mex.we) b[mex.rd] = 1'b0;
        if (instr_valid && m_ready() && m_dec().we) b[instr[10:8]] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mex <= '0;
            mbusy <= '0;
            for (int i = 0; i < 8; i++) mreg[i] <= '0;
        end else begin
            mbusy <= next_busy();
            if (wb_en && wb_addr != 3'd0) mreg[wb_addr] <= wb_data;
            if (instr_valid && m_ready()) mex <= m_dec();
            else if (!ex_stall || flush) mex.v <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("m_ready", 32'(instr_ready), 32'(m_ready()));
        chk("m_valid", 32'(ex_valid), 32'(mex.v));
        chk("m_opcode", 32'(ex_opcode), 32'(mex.op));
        chk("m_in1", 32'(ex_alu_in1), 32'(mex.a1));
        chk("m_in2", 32'(ex_alu_in2), 32'(mex.a2));
        chk("m_imm", 32'(ex_imm), 32'(mex.imm));
        chk("m_rd", 32'(ex_rd), 32'(mex.rd));
        chk("m_wben", 32'(ex_wb_en), 32'(mex.we));
        chk("m_sb", 32'(dut.sb), 32'(mbusy));
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] a, input logic [15:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cyc();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] i);
        instr = i; instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_addr = '0;
        wb_data = '0; ex_stall = 1'b0; flush = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset_valid", 32'(ex_valid), 0);
        chk("post_reset_ready", 32'(instr_ready), 1);

        wb(3'd1, 16'h0005);
        wb(3'd2, 16'h0003);
        issue({5'b11000, 3'd3, 3'd1, 3'd2, 2'b00});
        chk("rtype_valid", 32'(ex_valid), 1);
        chk("rtype_in1", 32'(ex_alu_in1), 32'h5);
        chk("rtype_in2", 32'(ex_alu_in2), 32'h3);
        chk("rtype_rd", 32'(ex_rd), 3);
        chk("rtype_wben", 32'(ex_wb_en), 1);
        chk("rtype_sb3", 32'(dut.sb[3]), 1);

        instr = {5'b01000, 3'd3, 8'h11}; instr_valid = 1'b1;
        cyc();
        chk("raw_stall0", 32'(instr_ready), 0);
        cyc();
        chk("raw_stall1", 32'(instr_ready), 0);
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h0008;
        #1 chk("raw_wb_ready", 32'(instr_ready), 32'(BYP));
        cyc();
        wb_en = 1'b0;
        if (!BYP) begin
            chk("raw_late_ready", 32'(instr_ready), 1);
            cyc();
        end
        instr_valid = 1'b0;
        chk("raw_valid", 32'(ex_valid), 1);
        chk("raw_in1", 32'(ex_alu_in1), 32'h8);
        chk("raw_op", 32'(ex_opcode), 32'h08);
        wb(3'd3, 16'h0008);

        issue({5'b11000, 3'd5, 3'd1, 3'd2, 2'b00});
        instr = {5'b11000, 3'd6, 3'd1, 3'd1, 2'b00}; instr_valid = 1'b1; ex_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_ready", 32'(instr_ready), 0);
            chk("stall_rd", 32'(ex_rd), 5);
            chk("stall_valid", 32'(ex_valid), 1);
            chk("stall_in1", 32'(ex_alu_in1), 32'h5);
        end
        ex_stall = 1'b0;
        cyc();
        instr_valid = 1'b0;
        chk("unstall_rd", 32'(ex_rd), 6);
        chk("unstall_in2", 32'(ex_alu_in2), 32'h5);
        wb(3'd5, 16'h0055);
        wb(3'd6, 16'h0066);

        issue({5'b10000, 3'd4, 3'd1, 5'd0});
        chk("load_wben", 32'(ex_wb_en), 1);
        instr = {5'b10100, 3'd4, 3'd2, 5'd0}; instr_valid = 1'b1; flush = 1'b1; ex_stall = 1'b1;
        #1 chk("flush_ready", 32'(instr_ready), 0);
        cyc();
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_sb4", 32'(dut.sb[4]), 0);
        flush = 1'b0; ex_stall = 1'b0;
        #1 chk("after_flush_ready", 32'(instr_ready), 1);
        cyc();
        instr_valid = 1'b0;
        chk("store_valid", 32'(ex_valid), 1);
        chk("store_op", 32'(ex_opcode), 32'h14);
        chk("store_in1", 32'(ex_alu_in1), 32'h3);
        chk("store_in2", 32'(ex_alu_in2), 32'h0);
        chk("store_wben", 32'(ex_wb_en), 0);

        issue({5'b01000, 3'd0, 8'hFF});
        chk("r0_imm", 32'(ex_imm), 32'hFF);
        chk("r0_wben", 32'(ex_wb_en), 0);
        chk("r0_sb", 32'(dut.sb), 0);
        wb(3'd0, 16'hBEEF);
        issue({5'b11000, 3'd1, 3'd0, 3'd0, 2'b00});
        chk("r0_read1", 32'(ex_alu_in1), 0);
        chk("r0_read2", 32'(ex_alu_in2), 0);
        issue({5'b00000, 3'd2, 8'h00});
        chk("j_wben", 32'(ex_wb_en), 0);
        chk("j_valid", 32'(ex_valid), 1);
        chk("pre_reset_sb1", 32'(dut.sb[1]), 1);

        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_op", 32'(ex_opcode), 0);
        chk("rst_in1", 32'(ex_alu_in1), 0);
        chk("rst_rd", 32'(ex_rd), 0);
        chk("rst_wben", 32'(ex_wb_en), 0);
        chk("rst_sb", 32'(dut.sb), 0);
        chk("rst_ready", 32'(instr_ready), 0);
        cyc();
        rst_n = 1'b1;
        issue({5'b11000, 3'd1, 3'd3, 3'd3, 2'b00});
        chk("rst_r3", 32'(ex_alu_in1), 0);
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Producer side of the execute stage: decodes one 16-bit instruction per cycle and presents registered opcode, operands and immediate to execute.
- Owns the 8x16 register file, the writeback write port and a scoreboard of pending destination writes.
- Stalls fetch on RAW hazards.
- Sits between fetch (valid/ready handshake) and execute (registered outputs, stall/flush control).

Parameters:
- NREGS, 8, number of architectural registers (R0 hardwired to zero).
- DW, 16, data/instruction width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  fetch presents an instruction
- instr  in  16  [15:11] opcode, [10:8] rd, [7:5] rs, [4:2] rt, [7:0] imm
- instr_ready  out  1  decode accepts instr this cycle
- wb_en  in  1  writeback write strobe
- wb_addr  in  3  writeback register
- wb_data  in  16  writeback data
- ex_stall  in  1  execute cannot accept; hold outputs
- flush  in  1  kill the instruction in the output register
- ex_valid  out  1  output register holds a live instruction
- ex_opcode  out  5  opcode to execute
- ex_alu_in1  out  16  R[rs] (R/M-type); R[rd] (I-type)
- ex_alu_in2  out  16  R[rt] (R-type); R[rd] store data (M-type store); 0 otherwise
- ex_imm  out  8  instr[7:0]
- ex_rd  out  3  destination register
- ex_wb_en  out  1  instruction writes ex_rd

Behaviour:
- Reset (async, rst_n low): all register-file entries 0, scoreboard 0, every ex_* output 0, instr_ready 0 while in reset.
- Class by opcode[4:3]: 11 R, 10 M, 01 I, 00 J.
- Writers: R; I; M with opcode[2]=0 (load). Non-writers: M store (opcode[2]=1) and J. An instruction with rd=R0 writes nothing (ex_wb_en=0).
- Sources:
  - R reads rs, rt.
  - I reads rd.
  - M load reads rs.
  - M store reads rs and rd.
  - J reads none.
  - R0 is never busy and always reads 0.
- Hazard: any source register has its scoreboard bit set, excluding a bit being cleared by wb_en this cycle (see optional feature).
- instr_ready = !ex_stall & !hazard & !flush. Issue = instr_valid & instr_ready.
- Output register update:
  - On issue, load all ex_* outputs and set ex_valid=1. Latency is 1 cycle from accept to ex_valid.
  - Else if ex_stall, hold.
  - Else ex_valid<=0; other outputs hold.
- Flush:
  - ex_valid<=0 next edge, and no issue that cycle.
  - If the killed instruction had ex_wb_en=1 and was valid, clear its scoreboard bit.
  - Flush overrides ex_stall.
- Scoreboard:
  - On issue with write, set bit rd.
  - On wb_en with wb_addr!=0, clear bit wb_addr.
  - Same register set and cleared in one cycle: set wins.
- Register file:
  - Synchronous write on wb_en (R0 ignored).
  - Combinational read.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: a read of the register written this cycle returns wb_data, and that register's busy bit is ignored for hazard, so a dependent instruction issues the same cycle as the writeback.
- Undefined: no bypass. The register is still treated as busy that cycle, so the dependent instruction stalls exactly one extra cycle and reads the new value from the file.

Decomposition:
- Shared package holds:
  - opcode-class constants (CLS_R=2'b11, CLS_M=2'b10, CLS_I=2'b01, CLS_J=2'b00);
  - M load/store bit index (2);
  - instruction field bit positions;
  - NREGS and register-address width.
- One sub-module, dec_regfile: 8x16, two combinational read ports plus the extra rd read for I/store, one write port, R0 zero, bypass under the macro.
- Scoreboard and output register stay in decode_stage.

Test Plan:
- Reset mid-run:
  - Stimulus: assert rst_n=0 with ex_valid=1 and scoreboard bits set.
  - Response: all ex_* are 0 and the scoreboard is 0 immediately. After release, reading R3 returns 0.
- Writeback then R-type:
  - Stimulus: wb R1=16'h0005, R2=16'h0003, then issue opcode 11000 rd=3 rs=1 rt=2.
  - Response: next cycle ex_valid=1, alu_in1=5, alu_in2=3, ex_rd=3, ex_wb_en=1, and scoreboard bit 3 is set.
- RAW stall:
  - Stimulus: issue a write to R3, then an instruction reading R3.
  - Response: instr_ready=0 until wb_en wb_addr=3 wb_data=16'h0008.
  - With the macro, issue happens that cycle and alu_in1=8. Without it, issue happens one cycle later, still with alu_in1=8.
- ex_stall hold:
  - Stimulus: ex_stall=1 for 3 cycles with a valid instruction.
  - Response: ex_* outputs are constant and instr_ready=0. After release, the next instruction issues.
- Flush:
  - Stimulus: flush=1 with a valid writer of R4 in the output register.
  - Response: ex_valid=0 next cycle, scoreboard bit 4 is cleared, and a following reader of R4 issues without stall.
- I-type and R0:
  - Stimulus: opcode 01000 rd=0 imm=8'hFF.
  - Response: ex_imm=8'hFF, ex_wb_en=0, and the scoreboard is unchanged. A wb_en to R0 leaves R0 reading 0.
